axi_lsu_router: RTL and testbench
=================================

AXI_LSU_ROUTER -- requirements
Module: axi_lsu_router

Interface
REQ-001 Parameter MIRROR_TAG, default 16'h8000: araddr[31:16]/awaddr[31:16] equal to this selects slave 1 (IROM mirror); any other value selects slave 0 (DRAM).
REQ-002 Parameter MAX_OUTST, default 4: maximum outstanding read bursts; range 1..15; read counter width 4 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m_axi_mosi_i  input  s_axi_mosi_t  LSU master request channels.
REQ-006 m_axi_miso_o  output  s_axi_miso_t  responses to LSU master.
REQ-007 s_axi_mosi_o  output  s_axi_mosi_t [1:0]  requests to slave 0 (DRAM) and slave 1 (mirror).
REQ-008 s_axi_miso_i  input  s_axi_miso_t [1:0]  responses from slaves 0 and 1.

Function
REQ-009 Read path: registers rd_route (1 bit) and rd_cnt (4 bits); AR target decoded combinationally from araddr.
REQ-010 AR forwarded (arvalid plus all AR fields) only to the decoded slave, and only when rd_cnt==0 or (target==rd_route and rd_cnt<MAX_OUTST); otherwise master sees arready=0 and both slaves see arvalid=0.
REQ-011 AR handshake (arvalid & forwarded slave's arready): rd_route<=target; rd_cnt increments.
REQ-012 R channel: master r* fields taken from slave rd_route; rready driven only to slave rd_route; other slave rready=0; if rd_cnt==0, master rvalid=0.
REQ-013 R handshake with rlast decrements rd_cnt; AR accept and rlast handshake in same cycle leaves rd_cnt unchanged.
REQ-014 rd_cnt never wraps: no AR accepted at MAX_OUTST; no decrement at 0 (rvalid masked).
REQ-015 Write path FSM, states WR_IDLE, WR_DATA, WR_RESP; register wr_route (1 bit).
REQ-016 WR_IDLE: awvalid forwarded to decoded slave; on AW handshake wr_route<=target, go WR_DATA; if W beat with wlast handshakes same cycle as AW, go directly WR_RESP.
REQ-017 W beats before AW handshake are not forwarded: master wready=0 in WR_IDLE unless AW handshakes that cycle.
REQ-018 WR_DATA: W fields/wvalid forwarded to slave wr_route, wready returned from it, awready to master=0; W handshake with wlast -> WR_RESP.
REQ-019 WR_RESP: bvalid/bresp from slave wr_route, bready only to it; B handshake -> WR_IDLE; awready to master=0.
REQ-020 Read and write paths independent; concurrent read and write to different slaves permitted.
REQ-021 Every field not explicitly forwarded to a slave is driven zero; every master response field not sourced is zero.
REQ-022 No combinational path from master valid to master ready except through the selected slave's ready; no added latency: all forwarding is same-cycle.

Reset
REQ-023 While rst=1: rd_cnt=0, rd_route=0, wr_route=0, FSM=WR_IDLE at next edge.
REQ-024 While rst=1, all outputs driven zero (all valid/ready to slaves and master =0) irrespective of inputs.
REQ-025 Reset asserted mid-burst abandons transactions; no pending state survives; first post-reset cycle behaves as idle.

Verification
REQ-026 AR araddr=0x8000_0010 with slave1 arready=1 -> slave1 arvalid=1, slave0 arvalid=0, rd_cnt=1; slave1 R rlast returns to master, rd_cnt=0.
REQ-027 Four ARs to 0x0000_0100.. back-to-back, slaves hold R -> 5th AR to DRAM stalled (master arready=0) until first rlast handshake.
REQ-028 rd_cnt=2 toward DRAM, AR to 0x8000_0000 -> stalled, slave1 arvalid=0 until rd_cnt reaches 0, then forwarded in that cycle.
REQ-029 AW 0x0000_0040 + W wlast same cycle -> FSM WR_RESP next cycle; bvalid from slave0 with bresp=0 reaches master; FSM WR_IDLE after B handshake.
REQ-030 AR accept and rlast handshake same cycle at rd_cnt=1 -> rd_cnt stays 1; rst=1 during WR_DATA -> all outputs 0, FSM WR_IDLE, rd_cnt=0 after edge.

Source files
------------

// File: rtl/axi_lsu_router.sv
// AXI LSU router: steers one LSU master onto DRAM (slave 0) or the IROM
// mirror (slave 1). Reads may pipeline several bursts to one slave; writes
// are handled one transaction at a time by a small FSM.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never waits for ready, and every ready seen by the
// master is the selected slave's ready gated only by routing state.

package axi_lsu_router_pkg;

   typedef struct packed {
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        arvalid;
      logic        rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic        awready;
      logic        wready;
      logic [1:0]  bresp;
      logic        bvalid;
      logic        arready;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
      logic        rvalid;
   } s_axi_miso_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2
   } wr_state_t;

endpackage

module axi_lsu_router
   import axi_lsu_router_pkg::*;
#(
   parameter logic [15:0] MIRROR_TAG = 16'h8000,
   parameter int          MAX_OUTST  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  s_axi_mosi_t       m_axi_mosi_i,
   output s_axi_miso_t       m_axi_miso_o,
   output s_axi_mosi_t [1:0] s_axi_mosi_o,
   input  s_axi_miso_t [1:0] s_axi_miso_i,
   output logic [1:0]        dbg_wr_state,
   output logic [3:0]        dbg_rd_cnt,
   output logic              dbg_rd_route,
   output logic              dbg_wr_route
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

   wr_state_t         wr_state;
   wr_state_t         wr_next;
   logic              wr_route;
   logic              rd_route;
   logic [3:0]        rd_cnt;

   logic              ar_tgt;
   logic              aw_tgt;
   logic              ar_ok;
   logic              ar_hs;
   logic              rlast_hs;
   logic              aw_hs;
   logic              wlast_hs;
   logic              b_hs;
   s_axi_miso_t       miso_c;
   s_axi_mosi_t [1:0] mosi_c;

   // Routing, forwarding, handshake detection and write FSM next state.
   always_comb begin
      mosi_c   = '0;
      miso_c   = '0;
      wr_next  = wr_state;
      ar_hs    = 1'b0;
      rlast_hs = 1'b0;
      aw_hs    = 1'b0;
      wlast_hs = 1'b0;
      b_hs     = 1'b0;

      ar_tgt = (m_axi_mosi_i.araddr[31:16] == MIRROR_TAG);
      aw_tgt = (m_axi_mosi_i.awaddr[31:16] == MIRROR_TAG);

      // A new AR may only join bursts already in flight to the same slave,
      // so R beats never need reordering between slaves.
      ar_ok = (rd_cnt == 4'd0) || ((ar_tgt == rd_route) && (rd_cnt < MAX_CNT));

      if (ar_ok) begin
         mosi_c[ar_tgt].araddr  = m_axi_mosi_i.araddr;
         mosi_c[ar_tgt].arlen   = m_axi_mosi_i.arlen;
         mosi_c[ar_tgt].arsize  = m_axi_mosi_i.arsize;
         mosi_c[ar_tgt].arburst = m_axi_mosi_i.arburst;
         mosi_c[ar_tgt].arvalid = m_axi_mosi_i.arvalid;
         miso_c.arready         = s_axi_miso_i[ar_tgt].arready;
      end
      ar_hs = m_axi_mosi_i.arvalid & miso_c.arready;

      // R beats come only from the slave owning the outstanding bursts.
      if (rd_cnt != 4'd0) begin
         miso_c.rdata            = s_axi_miso_i[rd_route].rdata;
         miso_c.rresp            = s_axi_miso_i[rd_route].rresp;
         miso_c.rlast            = s_axi_miso_i[rd_route].rlast;
         miso_c.rvalid           = s_axi_miso_i[rd_route].rvalid;
         mosi_c[rd_route].rready = m_axi_mosi_i.rready;
      end
      rlast_hs = miso_c.rvalid & m_axi_mosi_i.rready & miso_c.rlast;

      case (wr_state)
         WR_IDLE: begin
            mosi_c[aw_tgt].awaddr  = m_axi_mosi_i.awaddr;
            mosi_c[aw_tgt].awlen   = m_axi_mosi_i.awlen;
            mosi_c[aw_tgt].awsize  = m_axi_mosi_i.awsize;
            mosi_c[aw_tgt].awburst = m_axi_mosi_i.awburst;
            mosi_c[aw_tgt].awvalid = m_axi_mosi_i.awvalid;
            miso_c.awready         = s_axi_miso_i[aw_tgt].awready;
            aw_hs = m_axi_mosi_i.awvalid & miso_c.awready;
            // W is only let through in the same cycle the address is taken,
            // so a slave never sees data ahead of its address.
            if (aw_hs) begin
               mosi_c[aw_tgt].wdata  = m_axi_mosi_i.wdata;
               mosi_c[aw_tgt].wstrb  = m_axi_mosi_i.wstrb;
               mosi_c[aw_tgt].wlast  = m_axi_mosi_i.wlast;
               mosi_c[aw_tgt].wvalid = m_axi_mosi_i.wvalid;
               miso_c.wready         = s_axi_miso_i[aw_tgt].wready;
            end
            wlast_hs = m_axi_mosi_i.wvalid & miso_c.wready & m_axi_mosi_i.wlast;
            if (aw_hs) begin
               wr_next = wlast_hs ? WR_RESP : WR_DATA;
            end
         end
         WR_DATA: begin
            mosi_c[wr_route].wdata  = m_axi_mosi_i.wdata;
            mosi_c[wr_route].wstrb  = m_axi_mosi_i.wstrb;
            mosi_c[wr_route].wlast  = m_axi_mosi_i.wlast;
            mosi_c[wr_route].wvalid = m_axi_mosi_i.wvalid;
            miso_c.wready           = s_axi_miso_i[wr_route].wready;
            wlast_hs = m_axi_mosi_i.wvalid & miso_c.wready & m_axi_mosi_i.wlast;
            if (wlast_hs) begin
               wr_next = WR_RESP;
            end
         end
         WR_RESP: begin
            miso_c.bvalid           = s_axi_miso_i[wr_route].bvalid;
            miso_c.bresp            = s_axi_miso_i[wr_route].bresp;
            mosi_c[wr_route].bready = m_axi_mosi_i.bready;
            b_hs = miso_c.bvalid & m_axi_mosi_i.bready;
            if (b_hs) begin
               wr_next = WR_IDLE;
            end
         end
         default: wr_next = WR_IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held.
   always_comb begin
      m_axi_miso_o = rst ? '0 : miso_c;
      s_axi_mosi_o = rst ? '0 : mosi_c;
      dbg_wr_state = rst ? 2'd0 : wr_state;
      dbg_rd_cnt   = rst ? 4'd0 : rd_cnt;
      dbg_rd_route = rst ? 1'b0 : rd_route;
      dbg_wr_route = rst ? 1'b0 : wr_route;
   end

   // Write FSM state register and captured write route.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= WR_IDLE;
         wr_route <= 1'b0;
      end else begin
         wr_state <= wr_next;
         if (aw_hs) begin
            wr_route <= aw_tgt;
         end
      end
   end

   // Outstanding read burst counter and the slave they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt   <= 4'd0;
         rd_route <= 1'b0;
      end else begin
         if (ar_hs) begin
            rd_route <= ar_tgt;
         end
         case ({ar_hs, rlast_hs})
            2'b10:   rd_cnt <= rd_cnt + 4'd1;
            2'b01:   rd_cnt <= rd_cnt - 4'd1;
            default: rd_cnt <= rd_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lsu_router.sv
// Directed bench for axi_lsu_router: read pipelining and stalls, write FSM,
// reset behaviour.
module tb_axi_lsu_router;
   import axi_lsu_router_pkg::*;

   logic              clk;
   logic              rst;
   s_axi_mosi_t       m_mosi;
   s_axi_miso_t       m_miso;
   s_axi_mosi_t [1:0] s_mosi;
   s_axi_miso_t [1:0] s_miso;
   logic [1:0]        dbg_wr_state;
   logic [3:0]        dbg_rd_cnt;
   logic              dbg_rd_route;
   logic              dbg_wr_route;

   int checks;
   int failures;

   axi_lsu_router dut (
      .clk          (clk),
      .rst          (rst),
      .m_axi_mosi_i (m_mosi),
      .m_axi_miso_o (m_miso),
      .s_axi_mosi_o (s_mosi),
      .s_axi_miso_i (s_miso),
      .dbg_wr_state (dbg_wr_state),
      .dbg_rd_cnt   (dbg_rd_cnt),
      .dbg_rd_route (dbg_rd_route),
      .dbg_wr_route (dbg_wr_route)
   );

   // Clock: 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs settle here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m_mosi = '0;
      s_miso = '0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clear_inputs();
      rst = 1'b1;

      // Reset with busy inputs: everything must read zero.
      m_mosi.arvalid = 1'b1;
      m_mosi.araddr  = 32'h8000_0000;
      m_mosi.awvalid = 1'b1;
      m_mosi.wvalid  = 1'b1;
      m_mosi.rready  = 1'b1;
      m_mosi.bready  = 1'b1;
      s_miso[0].arready = 1'b1;
      s_miso[1].arready = 1'b1;
      s_miso[0].awready = 1'b1;
      s_miso[0].rvalid  = 1'b1;
      s_miso[0].bvalid  = 1'b1;
      tick();
      tick();
      chk("rst_m_miso", 256'(m_miso), 256'(0));
      chk("rst_s_mosi", 256'(s_mosi), 256'(0));
      clear_inputs();
      rst = 1'b0;
      #1;
      chk("rst_rd_cnt", 256'(dbg_rd_cnt), 256'(0));
      chk("rst_wr_state", 256'(dbg_wr_state), 256'(WR_IDLE));

      // Single read to the mirror.
      m_mosi.araddr     = 32'h8000_0010;
      m_mosi.arvalid    = 1'b1;
      m_mosi.arlen      = 8'd3;
      s_miso[1].arready = 1'b1;
      #1;
      chk("r1_s1_arvalid", 256'(s_mosi[1].arvalid), 256'(1));
      chk("r1_s0_arvalid", 256'(s_mosi[0].arvalid), 256'(0));
      chk("r1_s1_araddr", 256'(s_mosi[1].araddr), 256'(32'h8000_0010));
      chk("r1_s1_arlen", 256'(s_mosi[1].arlen), 256'(3));
      chk("r1_s0_araddr", 256'(s_mosi[0].araddr), 256'(0));
      chk("r1_m_arready", 256'(m_miso.arready), 256'(1));
      tick();
      chk("r1_cnt1", 256'(dbg_rd_cnt), 256'(1));
      chk("r1_route", 256'(dbg_rd_route), 256'(1));
      m_mosi.arvalid   = 1'b0;
      s_miso[1].rvalid = 1'b1;
      s_miso[1].rlast  = 1'b1;
      s_miso[1].rdata  = 32'hCAFE_0001;
      s_miso[0].rdata  = 32'h1111_2222;
      m_mosi.rready    = 1'b1;
      #1;
      chk("r1_m_rvalid", 256'(m_miso.rvalid), 256'(1));
      chk("r1_m_rdata", 256'(m_miso.rdata), 256'(32'hCAFE_0001));
      chk("r1_s1_rready", 256'(s_mosi[1].rready), 256'(1));
      chk("r1_s0_rready", 256'(s_mosi[0].rready), 256'(0));
      tick();
      chk("r1_cnt0", 256'(dbg_rd_cnt), 256'(0));
      clear_inputs();

      // Four DRAM reads fill the window; the fifth stalls.
      s_miso[0].arready = 1'b1;
      m_mosi.arvalid    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_mosi.araddr = 32'h0000_0100 + 32'(i * 4);
         #1;
         chk("r4_m_arready", 256'(m_miso.arready), 256'(1));
         tick();
      end
      chk("r4_cnt4", 256'(dbg_rd_cnt), 256'(4));
      m_mosi.araddr = 32'h0000_0110;
      #1;
      chk("r5_m_arready_stall", 256'(m_miso.arready), 256'(0));
      chk("r5_s0_arvalid_stall", 256'(s_mosi[0].arvalid), 256'(0));
      s_miso[0].rvalid = 1'b1;
      s_miso[0].rlast  = 1'b1;
      m_mosi.rready    = 1'b1;
      #1;
      chk("r5_still_stalled", 256'(m_miso.arready), 256'(0));
      tick();
      chk("r5_cnt3", 256'(dbg_rd_cnt), 256'(3));
      s_miso[0].rvalid = 1'b0;
      #1;
      chk("r5_m_arready_go", 256'(m_miso.arready), 256'(1));
      tick();
      chk("r5_cnt4", 256'(dbg_rd_cnt), 256'(4));
      m_mosi.arvalid   = 1'b0;
      s_miso[0].rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      chk("r5_drain_cnt0", 256'(dbg_rd_cnt), 256'(0));
      chk("r5_rvalid_masked", 256'(m_miso.rvalid), 256'(0));
      chk("r5_rready_masked", 256'(s_mosi[0].rready), 256'(0));
      tick();
      chk("r5_no_underflow", 256'(dbg_rd_cnt), 256'(0));
      clear_inputs();

      // Mirror read blocked behind DRAM bursts until they drain.
      s_miso[0].arready = 1'b1;
      m_mosi.arvalid    = 1'b1;
      m_mosi.araddr     = 32'h0000_0200;
      tick();
      m_mosi.araddr = 32'h0000_0204;
      tick();
      chk("x_cnt2", 256'(dbg_rd_cnt), 256'(2));
      m_mosi.araddr     = 32'h8000_0000;
      s_miso[1].arready = 1'b1;
      #1;
      chk("x_s1_arvalid_stall", 256'(s_mosi[1].arvalid), 256'(0));
      chk("x_m_arready_stall", 256'(m_miso.arready), 256'(0));
      s_miso[0].rvalid = 1'b1;
      s_miso[0].rlast  = 1'b1;
      m_mosi.rready    = 1'b1;
      tick();
      chk("x_cnt1", 256'(dbg_rd_cnt), 256'(1));
      chk("x_s1_arvalid_stall2", 256'(s_mosi[1].arvalid), 256'(0));
      tick();
      chk("x_cnt0", 256'(dbg_rd_cnt), 256'(0));
      chk("x_s1_arvalid_go", 256'(s_mosi[1].arvalid), 256'(1));
      chk("x_m_arready_go", 256'(m_miso.arready), 256'(1));
      chk("x_m_rvalid_masked", 256'(m_miso.rvalid), 256'(0));
      s_miso[0].rvalid = 1'b0;
      tick();
      chk("x_cnt1_mirror", 256'(dbg_rd_cnt), 256'(1));
      chk("x_route1", 256'(dbg_rd_route), 256'(1));

      // AR accept and rlast in the same cycle leave the count unchanged.
      s_miso[1].rvalid = 1'b1;
      s_miso[1].rlast  = 1'b1;
      m_mosi.araddr    = 32'h8000_0040;
      #1;
      chk("same_m_arready", 256'(m_miso.arready), 256'(1));
      tick();
      chk("same_cnt1", 256'(dbg_rd_cnt), 256'(1));
      m_mosi.arvalid = 1'b0;
      tick();
      chk("same_drain_cnt0", 256'(dbg_rd_cnt), 256'(0));
      clear_inputs();

      // Write with AW and last W beat together.
      m_mosi.awaddr     = 32'h0000_0040;
      m_mosi.awvalid    = 1'b1;
      m_mosi.wdata      = 32'hDEAD_BEEF;
      m_mosi.wstrb      = 4'hF;
      m_mosi.wvalid     = 1'b1;
      m_mosi.wlast      = 1'b1;
      s_miso[0].awready = 1'b1;
      s_miso[0].wready  = 1'b1;
      #1;
      chk("w_s0_awvalid", 256'(s_mosi[0].awvalid), 256'(1));
      chk("w_s1_awvalid", 256'(s_mosi[1].awvalid), 256'(0));
      chk("w_m_awready", 256'(m_miso.awready), 256'(1));
      chk("w_m_wready", 256'(m_miso.wready), 256'(1));
      chk("w_s0_wdata", 256'(s_mosi[0].wdata), 256'(32'hDEAD_BEEF));
      tick();
      chk("w_state_resp", 256'(dbg_wr_state), 256'(WR_RESP));
      clear_inputs();
      m_mosi.awvalid    = 1'b1;
      s_miso[0].awready = 1'b1;
      s_miso[0].bvalid  = 1'b1;
      s_miso[0].bresp   = 2'b00;
      s_miso[1].bvalid  = 1'b1;
      s_miso[1].bresp   = 2'b10;
      m_mosi.bready     = 1'b1;
      #1;
      chk("w_resp_m_awready", 256'(m_miso.awready), 256'(0));
      chk("w_m_bvalid", 256'(m_miso.bvalid), 256'(1));
      chk("w_m_bresp", 256'(m_miso.bresp), 256'(0));
      chk("w_s0_bready", 256'(s_mosi[0].bready), 256'(1));
      chk("w_s1_bready", 256'(s_mosi[1].bready), 256'(0));
      tick();
      chk("w_state_idle", 256'(dbg_wr_state), 256'(WR_IDLE));
      clear_inputs();

      // W ahead of AW is held back; then AW to mirror, concurrent DRAM read.
      m_mosi.awaddr     = 32'h8000_0080;
      m_mosi.awvalid    = 1'b1;
      m_mosi.wvalid     = 1'b1;
      m_mosi.wdata      = 32'h0000_00A5;
      s_miso[1].wready  = 1'b1;
      #1;
      chk("wa_m_wready_held", 256'(m_miso.wready), 256'(0));
      chk("wa_s1_wvalid_held", 256'(s_mosi[1].wvalid), 256'(0));
      chk("wa_s1_awvalid", 256'(s_mosi[1].awvalid), 256'(1));
      s_miso[1].awready = 1'b1;
      m_mosi.arvalid    = 1'b1;
      m_mosi.araddr     = 32'h0000_0300;
      s_miso[0].arready = 1'b1;
      #1;
      chk("wa_m_wready", 256'(m_miso.wready), 256'(1));
      chk("wa_s1_wvalid", 256'(s_mosi[1].wvalid), 256'(1));
      chk("wa_s0_arvalid", 256'(s_mosi[0].arvalid), 256'(1));
      tick();
      chk("wa_state_data", 256'(dbg_wr_state), 256'(WR_DATA));
      chk("wa_wr_route", 256'(dbg_wr_route), 256'(1));
      chk("wa_rd_cnt1", 256'(dbg_rd_cnt), 256'(1));
      m_mosi.arvalid = 1'b0;
      m_mosi.wdata   = 32'h0000_00B6;
      #1;
      chk("wd_m_awready0", 256'(m_miso.awready), 256'(0));
      chk("wd_s1_awvalid0", 256'(s_mosi[1].awvalid), 256'(0));
      chk("wd_s1_wdata", 256'(s_mosi[1].wdata), 256'(32'h0000_00B6));
      chk("wd_s0_wvalid", 256'(s_mosi[0].wvalid), 256'(0));

      // Reset in the middle of the write and read.
      rst              = 1'b1;
      m_mosi.arvalid   = 1'b1;
      m_mosi.rready    = 1'b1;
      s_miso[0].rvalid = 1'b1;
      #1;
      chk("mid_rst_m_miso", 256'(m_miso), 256'(0));
      chk("mid_rst_s_mosi", 256'(s_mosi), 256'(0));
      tick();
      clear_inputs();
      rst = 1'b0;
      #1;
      chk("post_rst_state", 256'(dbg_wr_state), 256'(WR_IDLE));
      chk("post_rst_cnt", 256'(dbg_rd_cnt), 256'(0));
      chk("post_rst_wready", 256'(m_miso.wready), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
